// File: rtl/io_bridge_pkg.sv
// Shared types and width helpers for the MMU-to-peripheral IO bridge.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_bits(input int n);
    return (n <= 2) ? 1 : clog2(n);
  endfunction

  function automatic int cnt_bits(input int t);
    return (clog2(t + 1) < 1) ? 1 : clog2(t + 1);
  endfunction

endpackage

// File: rtl/io_wait_counter.sv
// Wait-state counter for the ACCESS phase; flags the last allowed cycle.
module io_wait_counter
  import io_bridge_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign expired = (cnt == WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/io_bridge.sv
// Decodes one MMU IO request to an en/ack peripheral channel with timeout.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 15,
  localparam int SEL_W  = sel_bits(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W/8-1:0]      req_be,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [NUM_CH-1:0]        ch_en,
  output logic                     ch_we,
  output logic [ADDR_W-SEL_W-1:0]  ch_addr,
  output logic [DATA_W/8-1:0]      ch_be,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ack
);

  localparam int CW = cnt_bits(TIMEOUT);

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_q;
  logic               bad;
  logic               accept;
  logic               ack;
  logic               expired;
  logic               fin;
  logic               err_next;
  logic [DATA_W-1:0]  rdata_next;

  assign sel       = req_addr[ADDR_W-1 -: SEL_W];
  assign bad       = int'(sel) >= NUM_CH;
  assign accept    = (state == S_IDLE) && req_valid;
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  // ch_en is one-hot on sel_q, so this masks acks from unselected channels
  assign ack       = |(ch_ack & ch_en);

  io_wait_counter #(
    .WIDTH   (CW),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .inc     ((state == S_ACCESS) && !ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fin        = 1'b0;
    err_next   = 1'b0;
    rdata_next = '0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (bad) begin
            state_next = S_RESP;
            fin        = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (ack) begin
          state_next = S_RESP;
          fin        = 1'b1;
          if (!ch_we) begin
            rdata_next = ch_rdata[int'(sel_q)*DATA_W +: DATA_W];
          end
        end else if (expired) begin
          state_next = S_RESP;
          fin        = 1'b1;
          err_next   = 1'b1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_en     <= '0;
      ch_we     <= 1'b0;
      ch_addr   <= '0;
      ch_be     <= '0;
      ch_wdata  <= '0;
      sel_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        ch_we    <= req_we;
        ch_addr  <= req_addr[ADDR_W-SEL_W-1:0];
        ch_be    <= req_be;
        ch_wdata <= req_wdata;
        sel_q    <= sel;
        ch_en    <= bad ? '0 : (NUM_CH'(1) << sel);
      end
      if ((state == S_ACCESS) && fin) begin
        ch_en <= '0;
      end
      if (fin) begin
        rsp_rdata <= rdata_next;
        rsp_err   <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Directed vector bench for io_bridge (4-channel build plus a 3-channel build).
module tb_io_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [7:0]   req_addr;
  logic [3:0]   req_be;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   ch_en;
  logic         ch_we;
  logic [5:0]   ch_addr;
  logic [3:0]   ch_be;
  logic [31:0]  ch_wdata;
  logic [127:0] ch_rdata;
  logic [3:0]   ch_ack;

  logic         req_valid3;
  logic         req_ready3;
  logic         rsp_valid3;
  logic [31:0]  rsp_rdata3;
  logic         rsp_err3;
  logic [2:0]   ch_en3;
  logic         ch_we3;
  logic [5:0]   ch_addr3;
  logic [3:0]   ch_be3;
  logic [31:0]  ch_wdata3;
  logic [95:0]  ch_rdata3;
  logic [2:0]   ch_ack3;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  io_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ch_en     (ch_en),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_be     (ch_be),
    .ch_wdata  (ch_wdata),
    .ch_rdata  (ch_rdata),
    .ch_ack    (ch_ack)
  );

  io_bridge #(.NUM_CH(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid3),
    .rsp_rdata (rsp_rdata3),
    .rsp_err   (rsp_err3),
    .ch_en     (ch_en3),
    .ch_we     (ch_we3),
    .ch_addr   (ch_addr3),
    .ch_be     (ch_be3),
    .ch_wdata  (ch_wdata3),
    .ch_rdata  (ch_rdata3),
    .ch_ack    (ch_ack3)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ack_at;
    int          wrong;
    logic [31:0] prd;
    logic [3:0]  en;
    logic [31:0] rdata;
    logic        err;
    int          en_cyc;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    int ch, en_cyc, lat;
    bit done, en_ok;
    logic [31:0] held;
    ch = int'(t.addr[7:6]);
    @(negedge clk);
    chk({nm, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = t.we;
    req_addr  = t.addr;
    req_be    = t.be;
    req_wdata = t.wdata;
    for (int k = 0; k < 4; k++) begin
      ch_rdata[k*32 +: 32] = (k == ch) ? t.prd : 32'(32'h11111111 * (k + 1));
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~t.we;
    req_addr  = ~t.addr;
    req_be    = ~t.be;
    req_wdata = ~t.wdata;
    en_cyc = 0;
    lat    = 1;
    done   = 1'b0;
    en_ok  = 1'b1;
    while (!done && lat < 40) begin
      if (rsp_valid) begin
        done   = 1'b1;
        ch_ack = '0;
      end else begin
        ch_ack = '0;
        if (ch_en != '0) begin
          en_cyc++;
          if (ch_en !== t.en || ch_addr !== t.addr[5:0] || ch_be !== t.be ||
              ch_wdata !== t.wdata || ch_we !== t.we) en_ok = 1'b0;
          if (en_cyc == t.ack_at) ch_ack[ch] = 1'b1;
          if (t.wrong >= 0 && en_cyc < t.ack_at) ch_ack[t.wrong] = 1'b1;
        end
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, ".done"}, 64'(done), 64'd1);
    chk({nm, ".lat"}, 64'(lat), 64'(t.lat));
    chk({nm, ".en_cyc"}, 64'(en_cyc), 64'(t.en_cyc));
    chk({nm, ".latched"}, 64'(en_ok), 64'd1);
    chk({nm, ".rdata"}, 64'(rsp_rdata), 64'(t.rdata));
    chk({nm, ".err"}, 64'(rsp_err), 64'(t.err));
    held = rsp_rdata;
    @(negedge clk);
    chk({nm, ".strobe"}, 64'(rsp_valid), 64'd0);
    chk({nm, ".ready_back"}, 64'(req_ready), 64'd1);
    chk({nm, ".en_off"}, 64'(ch_en), 64'd0);
    chk({nm, ".hold"}, 64'(rsp_rdata), 64'(held));
  endtask

  initial begin
    bit seen;
    vecs[0] = '{1'b0, 8'h83, 4'hF, 32'h0, 1, -1, 32'hDEADBEEF,
                4'b0100, 32'hDEADBEEF, 1'b0, 1, 2};
    vecs[1] = '{1'b1, 8'h45, 4'b0011, 32'h12345678, 6, -1, 32'hAAAA5555,
                4'b0010, 32'h0, 1'b0, 6, 7};
    vecs[2] = '{1'b0, 8'hC7, 4'hF, 32'h0, 0, -1, 32'h55AA55AA,
                4'b1000, 32'h0, 1'b1, 15, 16};
    vecs[3] = '{1'b0, 8'h9F, 4'hF, 32'h0, 4, 0, 32'h0BADF00D,
                4'b0100, 32'h0BADF00D, 1'b0, 4, 5};
    vecs[4] = '{1'b0, 8'h10, 4'hF, 32'h0, 15, -1, 32'hCAFEF00D,
                4'b0001, 32'hCAFEF00D, 1'b0, 15, 16};
    vecs[5] = '{1'b0, 8'h7F, 4'b1100, 32'h0, 1, -1, 32'h13579BDF,
                4'b0010, 32'h13579BDF, 1'b0, 1, 2};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_be     = '0;
    req_wdata  = '0;
    ch_rdata   = '0;
    ch_ack     = '0;
    ch_rdata3  = {32'h33333333, 32'h22222222, 32'h11111111};
    ch_ack3    = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.err", 64'(rsp_err), 64'd0);
    chk("rst.rdata", 64'(rsp_rdata), 64'd0);
    chk("rst.en", 64'(ch_en), 64'd0);
    chk("rst.wdata", 64'(ch_wdata), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    @(negedge clk);
    req_addr   = 8'hC0;
    req_we     = 1'b0;
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("ch3.valid", 64'(rsp_valid3), 64'd1);
    chk("ch3.en", 64'(ch_en3), 64'd0);
    chk("ch3.err", 64'(rsp_err3), 64'd1);
    chk("ch3.rdata", 64'(rsp_rdata3), 64'd0);
    @(negedge clk);
    chk("ch3.strobe", 64'(rsp_valid3), 64'd0);
    chk("ch3.ready", 64'(req_ready3), 64'd1);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h45;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid.en", 64'(ch_en), 64'b0010);
    reset = 1'b1;
    #1;
    chk("mid.en_drop", 64'(ch_en), 64'd0);
    chk("mid.ready", 64'(req_ready), 64'd1);
    chk("mid.valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || ch_en != '0) seen = 1'b1;
    end
    chk("mid.quiet", 64'(seen), 64'd0);
    run_vec(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
